// File: rtl/prod_acc.sv
// prod_acc: saturating group accumulator behind the Booth multiplier.
// Sums LEN signed products per group and holds the result until accepted.
module prod_acc #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10,
  parameter int LEN    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic              busy
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] MAX_V =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             accept;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_w;
  logic             ovf;

  assign prod_ext =
    {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

  // One guard bit: sign mismatch of the top two bits flags overflow.
  assign sum_w =
    {acc[ACC_W-1], acc} +
    {prod_ext[ACC_W-1], prod_ext};
  assign ovf = sum_w[ACC_W] ^ sum_w[ACC_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = (LEN == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept && cnt == LAST) begin
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = !rst && (state != HOLD);
    busy     = (state != IDLE);
    accept   = in_valid && in_ready && !clr;
  end

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    sat_nxt = sat;
    if (accept) begin
      if (state == IDLE) begin
        acc_nxt = prod_ext;
        cnt_nxt = CNT_W'(1);
        sat_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
        sat_nxt = sat | ovf;
        unique case (1'b1)
          !ovf:
            acc_nxt = sum_w[ACC_W-1:0];
          ovf && sum_w[ACC_W]:
            acc_nxt = MIN_V;
          default:
            acc_nxt = MAX_V;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      sat <= sat_nxt;
    end
  end

  // Result registers load on entry to HOLD and stay frozen there.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (state != HOLD &&
                 state_nxt == HOLD) begin
      out_valid <= 1'b1;
      out_sum   <= acc_nxt;
      out_sat   <= sat_nxt;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end
  end

endmodule
